sram_march_bist: RTL and testbench
==================================

Name: sram_march_bist

Overview:
- Parametrised March C- BIST engine for the single-port SRAM macros (byte/bit-mask variants with a dedicated BIST port).
- Drives the macro's BIST port and takes over the array while bist_en_o is high. Compares read data against expected values with a configurable read latency, and reports pass/fail plus first-failure diagnostics.
- Sits beside each SRAM instance. Started and observed by the SoC test/control registers.

Parameters:
- DATA_WIDTH, 64: word width; width of bist_din_o, bist_bm_o, dout_i.
- ADDR_WIDTH, 10: address width.
- NUM_WORDS, 1024: words tested, addresses 0..NUM_WORDS-1; NUM_WORDS <= 2**ADDR_WIDTH, >= 2.
- READ_LATENCY, 1: cycles from a read op cycle to valid dout_i; legal values 1..3.
- CNT_WIDTH, 16: width of the saturating fail counter.

Ports:
- clk_i in 1: clock; also drives the macro's BIST clock.
- rst_ni in 1: reset, asynchronous, active-low.
- start_i in 1: single-cycle start request.
- abort_i in 1: stop the test, return to IDLE.
- bg_inv_i in 1: 0 = background 0/1 as all-zeros/all-ones; 1 = swapped.
- bist_en_o out 1: selects the BIST port in the macro.
- bist_men_o, bist_wen_o, bist_ren_o out 1 each: macro enable, write, read strobes.
- bist_addr_o out ADDR_WIDTH: op address.
- bist_din_o out DATA_WIDTH: write data.
- bist_bm_o out DATA_WIDTH: bit mask; all ones whenever bist_men_o is high, else 0.
- dout_i in DATA_WIDTH: macro read data.
- busy_o out 1: test in progress.
- done_o out 1: test complete; level signal.
- fail_o out 1: at least one miscompare; sticky until next start.
- fail_addr_o out ADDR_WIDTH: address of the first miscompare.
- fail_elem_o out 3: March element (0..5) of the first miscompare.
- fail_bits_o out DATA_WIDTH: XOR of expected and read data at the first miscompare.
- fail_cnt_o out CNT_WIDTH: miscompare count; saturates at all ones.

Behaviour:
- Reset: all outputs 0; FSM in IDLE.
- Reset asserted mid-test: immediate return to IDLE with all outputs 0, including bist_en_o and all diagnostics.
- FSM states:
  - IDLE -> RUN on start_i. Starting clears done/fail/diagnostics/counter.
  - RUN -> DRAIN after the last op.
  - DRAIN waits READ_LATENCY cycles for outstanding compares, then -> DONE.
  - DONE -> RUN on start_i.
- start_i while busy: ignored.
- abort_i (any state, priority over start_i):
  - next state IDLE; bist_en_o and strobes drop next cycle.
  - done_o = 0; fail/diagnostics hold their values.
- Elements (D = background-0 word, ~D = its complement):
  - E0 up (w D)
  - E1 up (r D, w ~D)
  - E2 up (r ~D, w D)
  - E3 down (r D, w ~D)
  - E4 down (r ~D, w D)
  - E5 up (r D)
- Op sequencing:
  - One op per cycle, no gaps. Read-then-write at the same address take consecutive cycles.
  - Total ops = 10*NUM_WORDS. "up" = address 0 to NUM_WORDS-1; "down" = NUM_WORDS-1 to 0.
  - Op outputs are registered. The first op is presented the cycle after start_i is sampled.
- Per-cycle strobe values: write op = men=1, wen=1, ren=0; read op = men=1, wen=0, ren=1; otherwise men=wen=ren=0.
- bist_en_o: 1 in RUN and DRAIN, and in DONE; 0 in IDLE.
- Compare pipeline:
  - Expected data, element, address and a valid bit go through a READ_LATENCY-deep shift register.
  - Compare happens at the cycle READ_LATENCY after the read op cycle. Writes never compare.
- On a miscompare:
  - fail_o set; fail_cnt_o incremented, saturating.
  - fail_addr/elem/bits captured only if fail_o was 0 before this compare.
- Status timing:
  - busy_o = 1 in RUN and DRAIN.
  - done_o = 1 in DONE only. It rises the cycle after the final compare, i.e. (10*NUM_WORDS + READ_LATENCY + 1) cycles after the start_i edge.
- Address counter wraps only via element transitions; it never exceeds NUM_WORDS-1.

Test Plan:
- NUM_WORDS=4, READ_LATENCY=1, fault-free macro model, start_i pulse:
  - 40 consecutive op cycles; done_o high at cycle 42 after start.
  - fail_o=0, fail_cnt_o=0; bist_addr_o sequence in E3 is 3,3,2,2,1,1,0,0.
- Same config with bit 5 of address 2 stuck-at-1:
  - fail_o=1, fail_addr_o=2, fail_elem_o=1, fail_bits_o=0x20.
  - fail_cnt_o=3 (reads of D in E1, E3, E5).
- READ_LATENCY=3 with a matching delayed model:
  - no false failures; done_o at cycle 44.
  - injecting an error on the 7th read flags the correct address.
- abort_i at op 15:
  - bist_en_o=0 next cycle; busy_o=0, done_o=0.
  - a subsequent start_i runs a full clean test.
- rst_ni low at op 20:
  - all outputs 0 asynchronously; no op strobes until a new start_i.
  - start_i asserted during RUN is ignored: op count stays 40.
- bg_inv_i=1: E0 writes all ones. A stuck-at-0 bit fails first in E1, with fail_elem_o=1.

Source files
------------

// File: rtl/sram_march_bist.sv
// March C- BIST engine for a single-port SRAM BIST port. It issues 10*NUM_WORDS ops
// back to back, checks reads READ_LATENCY cycles later and keeps first-fail diagnostics.
module sram_march_bist #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_WORDS    = 1024,
  parameter int READ_LATENCY = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  bg_inv_i,
  output logic                  bist_en_o,
  output logic                  bist_men_o,
  output logic                  bist_wen_o,
  output logic                  bist_ren_o,
  output logic [ADDR_WIDTH-1:0] bist_addr_o,
  output logic [DATA_WIDTH-1:0] bist_din_o,
  output logic [DATA_WIDTH-1:0] bist_bm_o,
  input  logic [DATA_WIDTH-1:0] dout_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [2:0]            fail_elem_o,
  output logic [DATA_WIDTH-1:0] fail_bits_o,
  output logic [CNT_WIDTH-1:0]  fail_cnt_o
);
  localparam int L = READ_LATENCY;
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
  localparam logic [1:0]            DRAIN_LAST = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] exp;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            elem;
  } cmp_t;

  state_t state, state_d;
  logic   ph, ph_d, bg, bg_d;
  logic [1:0] drain_cnt;
  logic   en, men, wen;
  logic [DATA_WIDTH-1:0] din;

  // Stage 0 is the op currently on the BIST port; stage L lines up with dout_i.
  logic [L:0] vld_pipe;
  cmp_t [L:0] cmp_pipe;
  cmp_t       cmp_in;

  logic [2:0]            e_cur, elem_d, elem_nx;
  logic [ADDR_WIDTH-1:0] a_cur, addr_d;
  logic two_cur, down_cur, at_end, last_op;
  logic op, launch, two_d, wr_d, rd_d;
  logic [DATA_WIDTH-1:0] d_word, wdata, rexp;

  assign e_cur    = cmp_pipe[0].elem;
  assign a_cur    = cmp_pipe[0].addr;
  assign two_cur  = (e_cur >= 3'd1) && (e_cur <= 3'd4);
  assign down_cur = (e_cur == 3'd3) || (e_cur == 3'd4);
  assign at_end   = down_cur ? (a_cur == '0) : (a_cur == LAST);
  assign last_op  = (e_cur == 3'd5) && (a_cur == LAST);
  assign elem_nx  = e_cur + 3'd1;

  always_comb begin
    state_d = state;
    op      = 1'b0;
    launch  = 1'b0;
    elem_d  = e_cur;
    addr_d  = a_cur;
    ph_d    = ph;
    case (state)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = RUN;
          op      = 1'b1;
          launch  = 1'b1;
          elem_d  = '0;
          addr_d  = '0;
          ph_d    = 1'b0;
        end
      end
      RUN: begin
        if (last_op) begin
          state_d = DRAIN;
        end else begin
          op = 1'b1;
          if (two_cur && !ph) begin
            ph_d = 1'b1;
          end else begin
            ph_d = 1'b0;
            if (at_end) begin
              elem_d = elem_nx;
              addr_d = (elem_nx == 3'd3 || elem_nx == 3'd4) ? LAST : '0;
            end else begin
              addr_d = down_cur ? a_cur - ONE : a_cur + ONE;
            end
          end
        end
      end
      DRAIN: if (drain_cnt == DRAIN_LAST) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d = IDLE;
      op      = 1'b0;
      launch  = 1'b0;
    end
  end

  // Background is latched at start so bg_inv_i may change mid-test without effect.
  assign bg_d   = launch ? bg_inv_i : bg;
  assign d_word = {DATA_WIDTH{bg_d}};
  assign two_d  = (elem_d >= 3'd1) && (elem_d <= 3'd4);
  assign wr_d   = op && ((elem_d == 3'd0) || (two_d && ph_d));
  assign rd_d   = op && !wr_d;
  assign wdata  = (elem_d == 3'd1 || elem_d == 3'd3) ? ~d_word : d_word;
  assign rexp   = (elem_d == 3'd2 || elem_d == 3'd4) ? ~d_word : d_word;

  always_comb begin
    cmp_in      = '0;
    cmp_in.exp  = rd_d ? rexp : '0;
    cmp_in.addr = op ? addr_d : '0;
    cmp_in.elem = op ? elem_d : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      ph        <= 1'b0;
      bg        <= 1'b0;
      drain_cnt <= '0;
      en        <= 1'b0;
      men       <= 1'b0;
      wen       <= 1'b0;
      din       <= '0;
      vld_pipe  <= '0;
      cmp_pipe  <= '0;
    end else begin
      state     <= state_d;
      ph        <= ph_d;
      bg        <= bg_d;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      en        <= (state_d != IDLE);
      men       <= op;
      wen       <= wr_d;
      din       <= wr_d ? wdata : '0;
      vld_pipe  <= abort_i ? '0 : {vld_pipe[L-1:0], rd_d};
      cmp_pipe  <= {cmp_pipe[L-1:0], cmp_in};
    end
  end

  logic [DATA_WIDTH-1:0] diff;
  logic                  miscmp;

  assign diff   = dout_i ^ cmp_pipe[L].exp;
  assign miscmp = vld_pipe[L] && !abort_i && (|diff);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_elem_o <= '0;
      fail_bits_o <= '0;
      fail_cnt_o  <= '0;
    end else if (launch) begin
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_elem_o <= '0;
      fail_bits_o <= '0;
      fail_cnt_o  <= '0;
    end else if (miscmp) begin
      fail_o <= 1'b1;
      if (~&fail_cnt_o) fail_cnt_o <= fail_cnt_o + CNT_ONE;
      if (!fail_o) begin
        fail_addr_o <= cmp_pipe[L].addr;
        fail_elem_o <= cmp_pipe[L].elem;
        fail_bits_o <= diff;
      end
    end
  end

  assign bist_en_o   = en;
  assign bist_men_o  = men;
  assign bist_wen_o  = wen;
  assign bist_ren_o  = vld_pipe[0];
  assign bist_addr_o = cmp_pipe[0].addr;
  assign bist_din_o  = din;
  assign bist_bm_o   = {DATA_WIDTH{men}};
  assign busy_o      = (state == RUN) || (state == DRAIN);
  assign done_o      = (state == DONE);

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: a READ_LATENCY=1 and a READ_LATENCY=3 instance run side by
// side against fault-injectable SRAM models; an op scoreboard checks every BIST port cycle.
module tb_sram_march_bist;
  localparam int DW = 64, AW = 10, NW = 4, CW = 16;

  typedef struct packed {
    logic          wen;
    logic          ren;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } op_t;

  logic clk = 1'b0, rst_ni = 1'b0, start_i = 1'b0, abort_i = 1'b0, bg_inv_i = 1'b0;
  always #5 clk = ~clk;

  logic          en[2], men[2], wen[2], ren[2], busy[2], done[2], fail[2];
  logic [AW-1:0] addr[2], faddr[2];
  logic [DW-1:0] din[2], bm[2], fbits[2];
  logic [2:0]    felem[2];
  logic [CW-1:0] fcnt[2];
  logic [DW-1:0] dout0, dout1;

  sram_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW),
                    .READ_LATENCY(1), .CNT_WIDTH(CW)) u_l1 (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i), .bg_inv_i(bg_inv_i),
    .bist_en_o(en[0]), .bist_men_o(men[0]), .bist_wen_o(wen[0]), .bist_ren_o(ren[0]),
    .bist_addr_o(addr[0]), .bist_din_o(din[0]), .bist_bm_o(bm[0]), .dout_i(dout0),
    .busy_o(busy[0]), .done_o(done[0]), .fail_o(fail[0]), .fail_addr_o(faddr[0]),
    .fail_elem_o(felem[0]), .fail_bits_o(fbits[0]), .fail_cnt_o(fcnt[0]));

  sram_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW),
                    .READ_LATENCY(3), .CNT_WIDTH(CW)) u_l3 (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i), .bg_inv_i(bg_inv_i),
    .bist_en_o(en[1]), .bist_men_o(men[1]), .bist_wen_o(wen[1]), .bist_ren_o(ren[1]),
    .bist_addr_o(addr[1]), .bist_din_o(din[1]), .bist_bm_o(bm[1]), .dout_i(dout1),
    .busy_o(busy[1]), .done_o(done[1]), .fail_o(fail[1]), .fail_addr_o(faddr[1]),
    .fail_elem_o(felem[1]), .fail_bits_o(fbits[1]), .fail_cnt_o(fcnt[1]));

  // SRAM models with one faulty word (stuck-at masks) and an optional one-shot read flip.
  logic [AW-1:0] f_addr;
  logic [DW-1:0] sa1_m, sa0_m, v1;
  logic [DW-1:0] mem0[NW], mem1[NW], rp1[3];
  int rd_n1 = 0, inj_at = -1;

  function automatic logic [DW-1:0] flt(input logic [DW-1:0] v, input logic [AW-1:0] a);
    return (a == f_addr) ? ((v | sa1_m) & ~sa0_m) : v;
  endfunction

  always @(posedge clk) begin
    if (men[0] && wen[0]) mem0[addr[0][1:0]] <= din[0];
    if (men[0] && ren[0]) dout0 <= flt(mem0[addr[0][1:0]], addr[0]);
  end

  always @(posedge clk) begin
    if (men[1] && wen[1]) mem1[addr[1][1:0]] <= din[1];
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
    if (men[1] && ren[1]) begin
      v1 = flt(mem1[addr[1][1:0]], addr[1]);
      if (rd_n1 + 1 == inj_at) v1[0] = ~v1[0];
      rd_n1 <= rd_n1 + 1;
      rp1[0] <= v1;
    end
  end
  assign dout1 = rp1[2];

  // Scoreboard of expected BIST port ops, one queue per instance.
  op_t q0[$], q1[$];
  op_t mon_e;
  logic mon_have;
  int ops[2];
  int checks = 0, errors = 0;

  initial begin
    ops[0] = 0;
    ops[1] = 0;
  end

  always @(negedge clk) begin
    if (rst_ni) begin
      for (int d = 0; d < 2; d++) begin
        if (men[d]) begin
          ops[d] = ops[d] + 1;
          checks++;
          mon_have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
          if (!mon_have) begin
            errors++;
            $display("FAIL op_unexpected dut%0d got w=%0b r=%0b a=%0d required no op",
                     d, wen[d], ren[d], addr[d]);
          end else begin
            if (d == 0) mon_e = q0.pop_front();
            else        mon_e = q1.pop_front();
            if (wen[d] !== mon_e.wen || ren[d] !== mon_e.ren || addr[d] !== mon_e.addr ||
                (mon_e.wen && din[d] !== mon_e.din) || bm[d] !== '1 || en[d] !== 1'b1) begin
              errors++;
              $display("FAIL op_seq dut%0d got w=%0b r=%0b a=%0d din=%h en=%0b required w=%0b r=%0b a=%0d din=%h en=1",
                       d, wen[d], ren[d], addr[d], din[d], en[d],
                       mon_e.wen, mon_e.ren, mon_e.addr, mon_e.din);
            end
          end
        end
      end
    end
  end

  function automatic bit all_zero(input int d);
    return {en[d], men[d], wen[d], ren[d], busy[d], done[d], fail[d]} == 7'b0 &&
           addr[d] == '0 && din[d] == '0 && bm[d] == '0 && faddr[d] == '0 &&
           felem[d] == '0 && fbits[d] == '0 && fcnt[d] == '0;
  endfunction

  task automatic push_ops(input bit bg);
    logic [DW-1:0] dw;
    op_t o;
    int a;
    dw = {DW{bg}};
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < NW; i++) begin
        a = (e == 3 || e == 4) ? NW - 1 - i : i;
        if (e != 0) begin
          o.wen = 1'b0; o.ren = 1'b1; o.addr = AW'(a); o.din = '0;
          q0.push_back(o); q1.push_back(o);
        end
        if (e != 5) begin
          o.wen = 1'b1; o.ren = 1'b0; o.addr = AW'(a);
          o.din = (e == 1 || e == 3) ? ~dw : dw;
          q0.push_back(o); q1.push_back(o);
        end
      end
    end
  endtask

  // Full run; done_o is expected in cycle 10*NW+L+1 counting the start cycle as 0.
  task automatic run_test(input bit bg, input bit poke_start);
    int b0, b1, dc0, dc1;
    @(negedge clk);
    bg_inv_i = bg;
    start_i  = 1'b1;
    push_ops(bg);
    b0 = ops[0]; b1 = ops[1];
    dc0 = -1; dc1 = -1;
    for (int c = 1; c <= 120 && (dc0 < 0 || dc1 < 0); c++) begin
      @(negedge clk);
      start_i = poke_start && (c == 10);
      if (c == 1) begin
        checks++;
        if (fail[0] !== 1'b0 || fail[1] !== 1'b0 || fcnt[0] !== '0 || fcnt[1] !== '0 ||
            busy[0] !== 1'b1 || busy[1] !== 1'b1 || done[0] !== 1'b0 || done[1] !== 1'b0) begin
          errors++;
          $display("FAIL start_clear got fail=%0b/%0b cnt=%0d/%0d busy=%0b/%0b done=%0b/%0b required 0,0,1,0",
                   fail[0], fail[1], fcnt[0], fcnt[1], busy[0], busy[1], done[0], done[1]);
        end
      end
      if (done[0] === 1'b1 && dc0 < 0) dc0 = c;
      if (done[1] === 1'b1 && dc1 < 0) dc1 = c;
    end
    start_i = 1'b0;
    checks++;
    if (dc0 != 42 || dc1 != 44) begin
      errors++;
      $display("FAIL done_cycle got l1=%0d l3=%0d required 42 44", dc0, dc1);
    end
    checks++;
    if (ops[0] - b0 != 40 || ops[1] - b1 != 40 || q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL op_count got %0d/%0d left %0d/%0d required 40/40 left 0/0",
               ops[0] - b0, ops[1] - b1, q0.size(), q1.size());
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (all_zero(d) !== 1'b1) begin
        errors++;
        $display("FAIL reset_state dut%0d got en=%0b busy=%0b done=%0b fail=%0b cnt=%0d required all 0",
                 d, en[d], busy[d], done[d], fail[d], fcnt[d]);
      end
    end
    #2 rst_ni = 1'b1;
  endtask

  task automatic test_stuck1;
    f_addr = AW'(2); sa1_m = 64'h20; sa0_m = '0;
    run_test(1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (fail[d] !== 1'b1 || faddr[d] !== AW'(2) || felem[d] !== 3'd1 ||
          fbits[d] !== 64'h20 || fcnt[d] !== CW'(3)) begin
        errors++;
        $display("FAIL stuck1_diag dut%0d got f=%0b a=%0d e=%0d bits=%h cnt=%0d required 1 2 1 20 3",
                 d, fail[d], faddr[d], felem[d], fbits[d], fcnt[d]);
      end
    end
  endtask

  task automatic test_clean;
    sa1_m = '0; sa0_m = '0;
    run_test(1'b0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (fail[d] !== 1'b0 || fcnt[d] !== '0 || done[d] !== 1'b1) begin
        errors++;
        $display("FAIL clean dut%0d got fail=%0b cnt=%0d done=%0b required 0 0 1",
                 d, fail[d], fcnt[d], done[d]);
      end
    end
  endtask

  task automatic test_inject;
    inj_at = rd_n1 + 7;
    run_test(1'b0, 1'b0);
    inj_at = -1;
    checks++;
    if (fail[0] !== 1'b0 || fcnt[0] !== '0) begin
      errors++;
      $display("FAIL inject_l1 got fail=%0b cnt=%0d required 0 0", fail[0], fcnt[0]);
    end
    checks++;
    if (fail[1] !== 1'b1 || faddr[1] !== AW'(2) || felem[1] !== 3'd2 ||
        fbits[1] !== 64'h1 || fcnt[1] !== CW'(1)) begin
      errors++;
      $display("FAIL inject_l3 got f=%0b a=%0d e=%0d bits=%h cnt=%0d required 1 2 2 1 1",
               fail[1], faddr[1], felem[1], fbits[1], fcnt[1]);
    end
  endtask

  task automatic test_abort;
    f_addr = AW'(2); sa1_m = 64'h20; sa0_m = '0;
    @(negedge clk);
    start_i = 1'b1;
    push_ops(1'b0);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (c == 15) abort_i = 1'b1;
    end
    @(negedge clk);
    abort_i = 1'b0;
    q0.delete(); q1.delete();
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (en[d] !== 1'b0 || men[d] !== 1'b0 || busy[d] !== 1'b0 || done[d] !== 1'b0 ||
            fail[d] !== 1'b1 || faddr[d] !== AW'(2) || felem[d] !== 3'd1 || fcnt[d] !== CW'(1)) begin
          errors++;
          $display("FAIL abort_state dut%0d got en=%0b men=%0b busy=%0b done=%0b f=%0b a=%0d e=%0d cnt=%0d required 0 0 0 0 1 2 1 1",
                   d, en[d], men[d], busy[d], done[d], fail[d], faddr[d], felem[d], fcnt[d]);
        end
      end
      repeat (3) @(negedge clk);
    end
    sa1_m = '0;
    run_test(1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (fail[d] !== 1'b0 || fcnt[d] !== '0) begin
        errors++;
        $display("FAIL abort_rerun dut%0d got fail=%0b cnt=%0d required 0 0", d, fail[d], fcnt[d]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int b0, b1;
    @(negedge clk);
    start_i = 1'b1;
    push_ops(1'b0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    #1 rst_ni = 1'b0;
    #1;
    q0.delete(); q1.delete();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (all_zero(d) !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid dut%0d got en=%0b men=%0b busy=%0b a=%0d required all 0",
                 d, en[d], men[d], busy[d], addr[d]);
      end
    end
    @(negedge clk);
    #2 rst_ni = 1'b1;
    b0 = ops[0]; b1 = ops[1];
    repeat (10) @(negedge clk);
    checks++;
    if (ops[0] != b0 || ops[1] != b1 || en[0] !== 1'b0 || en[1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet got ops=%0d/%0d en=%0b/%0b required 0/0 0/0",
               ops[0] - b0, ops[1] - b1, en[0], en[1]);
    end
  endtask

  task automatic test_bg_inv;
    f_addr = AW'(1); sa1_m = '0; sa0_m = 64'h1;
    run_test(1'b1, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (fail[d] !== 1'b1 || faddr[d] !== AW'(1) || felem[d] !== 3'd1 ||
          fbits[d] !== 64'h1 || fcnt[d] !== CW'(3)) begin
        errors++;
        $display("FAIL bg_inv_diag dut%0d got f=%0b a=%0d e=%0d bits=%h cnt=%0d required 1 1 1 1 3",
                 d, fail[d], faddr[d], felem[d], fbits[d], fcnt[d]);
      end
    end
    sa0_m = '0;
  endtask

  initial begin
    f_addr = '1; sa1_m = '0; sa0_m = '0;
    test_reset;
    test_stuck1;
    test_clean;
    test_inject;
    test_abort;
    test_reset_mid;
    test_bg_inv;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
